ux607_reset_sequencer: RTL and testbench
========================================

# ux607_reset_sequencer

Generates the block-level reset requests that `ux607_ResetCatchAndSync` instances consume. It merges power-on, software, watchdog and debug reset sources, stretches the result to a minimum assertion width, and releases N reset domains one at a time in a fixed order. It also keeps a sticky cause register for software. It sits in the always-on peripheral area, clocked from the always-on clock, with one output per downstream domain.

## Interface
- `STRETCH_CYCLES`, default 16: minimum number of cycles all outputs stay high after the last active request; must be ≥1.
- `GAP_CYCLES`, default 4: cycles between consecutive domain releases; must be ≥1.
- `N_DOMAINS`, default 3: number of reset domains driven; must be ≥1.
- `clock`  in  1  single block clock.
- `reset`  in  1  synchronous, active-high reset; treated as the power-on source.
- `sw_rst_req`  in  1  single-cycle software reset request.
- `wdt_rst_req`  in  1  single-cycle watchdog reset request.
- `dbg_rst_req`  in  1  level debug reset request; the reset is held while this is high.
- `io_cause_clr`  in  1  single-cycle clear of the cause register.
- `io_rst_out`  out  N_DOMAINS  active-high reset per domain; bit 0 is released first.
- `io_rst_busy`  out  1  high while any `io_rst_out` bit is high.
- `io_rst_cause`  out  4  sticky cause bits: [0] POR, [1] SW, [2] WDT, [3] DBG.

## Operation
- FSM has three states:
  - IDLE: all outputs low.
  - ASSERT: all outputs high; stretch counter running.
  - RELEASE: domains drop in order, one every GAP_CYCLES.
- "Request active" means `sw_rst_req | wdt_rst_req | dbg_rst_req`, with the debug term gated by the configuration macro.
- IDLE → ASSERT when a request is active; the counter loads STRETCH_CYCLES-1.
- ASSERT:
  - A request in any cycle reloads the counter.
  - The counter decrements when no request is active.
  - ASSERT → RELEASE when the counter is 0 and no request is active.
- RELEASE:
  - Domain index k starts at 0.
  - On entry, `io_rst_out[0]` clears.
  - Every GAP_CYCLES, the next index clears.
  - After bit N_DOMAINS-1 clears, go to IDLE.
- A request during RELEASE returns to ASSERT: all bits re-set, counter reloaded, index reset to 0.
- Cause register:
  - Each accepted request sets its bit, whatever the state.
  - `io_cause_clr` zeroes all bits.
  - If a clear and a set occur in the same cycle, the set wins for that bit and the other bits clear.
- Arithmetic: one shared down-counter, width $clog2(max(STRETCH_CYCLES, GAP_CYCLES)) with a minimum of 1; no wrap, because the counter is only decremented while nonzero.
- With N_DOMAINS=1, RELEASE lasts one cycle and goes straight to IDLE.

## Timing
- Under `reset`:
  - `io_rst_out` = all ones, `io_rst_busy` = 1, `io_rst_cause` = 4'b0001.
  - State = ASSERT, counter = STRETCH_CYCLES-1.
- After `reset` falls, the first deassertion of `io_rst_out[0]` occurs STRETCH_CYCLES cycles later, absent any request.
- Request sampled in cycle t → all `io_rst_out` high from cycle t+1; registered, no combinational path.
- Last request active in cycle t → `io_rst_out[0]` low from cycle t+STRETCH_CYCLES+1.
- `io_rst_out[k]` falls GAP_CYCLES after `io_rst_out[k-1]`.
- `io_rst_busy` falls in the same cycle as the last domain bit.
- Cause bits update one cycle after the request or clear.
- A reset asserted in the middle of any state overrides everything and returns all outputs to their reset values in the next cycle.

## Configuration
- Macro `UX607_RESET_SEQ_DBG_EN`.
- Defined: `dbg_rst_req` participates in requests and sets cause bit [3].
- Undefined: the port is kept but ignored, and cause bit [3] is constant 0.

## Structure
- Package `ux607_reset_pkg` holds:
  - the state enum (IDLE, ASSERT, RELEASE);
  - the cause bit index constants (CAUSE_POR=0, CAUSE_SW=1, CAUSE_WDT=2, CAUSE_DBG=3);
  - the cause width constant (4).
- One sub-module, `ux607_reset_cnt`: a loadable down-counter with load, decrement and zero-flag.
- The FSM and cause register live in the top module.

## Test plan
- Defaults; deassert `reset` at cycle 0 → `io_rst_out[0]` low at cycle 16, [1] at 20, [2] at 24; busy low at 24; cause = 0001.
- `io_cause_clr`, then `sw_rst_req` pulse at cycle 100 → all outputs high at 101; [0] low at 117; cause = 0010.
- `wdt_rst_req` pulse two cycles after [0] released → all bits re-asserted next cycle; release sequence restarts 16 cycles after the pulse; cause bit [2] set.
- With the macro defined, `dbg_rst_req` high for 50 cycles → outputs stay high for those 50 cycles plus 16; cause bit [3] set. With the macro undefined → no effect; cause bit [3] stays 0.
- `io_cause_clr` and `sw_rst_req` in the same cycle with cause = 0101 → cause = 0010.
- Assert `reset` in the middle of RELEASE → next cycle all outputs high, cause = 0001, state ASSERT.

Source files
------------

// File: rtl/ux607_reset_sequencer_pkg.sv
// Shared types and constants for the ux607 reset sequencer: FSM states,
// cause-register bit positions, and the counter width helper.
package ux607_reset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE
    } rst_state_e;

    localparam int unsigned CAUSE_W   = 4;
    localparam int unsigned CAUSE_POR = 0;
    localparam int unsigned CAUSE_SW  = 1;
    localparam int unsigned CAUSE_WDT = 2;
    localparam int unsigned CAUSE_DBG = 3;

    // One counter serves both the stretch and the gap phases, so it must hold
    // the larger of the two reload values.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ux607_reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and its users.
// master: request sources and cause consumers; slave: the sequencer itself.
interface ux607_reset_sequencer_if
    import ux607_reset_pkg::*;
#(
    parameter int unsigned N_DOMAINS = 3
);
    logic                 sw_rst_req;
    logic                 wdt_rst_req;
    logic                 dbg_rst_req;
    logic                 io_cause_clr;
    logic [N_DOMAINS-1:0] io_rst_out;
    logic                 io_rst_busy;
    logic [CAUSE_W-1:0]   io_rst_cause;

    modport master (
        output sw_rst_req,
        output wdt_rst_req,
        output dbg_rst_req,
        output io_cause_clr,
        input  io_rst_out,
        input  io_rst_busy,
        input  io_rst_cause
    );

    modport slave (
        input  sw_rst_req,
        input  wdt_rst_req,
        input  dbg_rst_req,
        input  io_cause_clr,
        output io_rst_out,
        output io_rst_busy,
        output io_rst_cause
    );

endinterface

// File: rtl/ux607_reset_sequencer_cnt.sv
// Loadable down-counter with zero flag; load has priority over decrement and
// decrement is ignored at zero so the count never wraps.
module ux607_reset_cnt #(
    parameter int unsigned W       = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ux607_reset_sequencer.sv
// Merges POR/SW/WDT/DBG reset sources, stretches them and releases domains in order.
// Define UX607_RESET_SEQ_DBG_EN to let dbg_rst_req request resets and set cause[3].
module ux607_reset_sequencer
    import ux607_reset_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned N_DOMAINS      = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    ux607_reset_sequencer_if.slave   rst_if
);

    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("STRETCH_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1");
    end
    if (N_DOMAINS < 1) begin : g_bad_ndom
        $error("N_DOMAINS must be >= 1");
    end

    localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES, GAP_CYCLES);
    localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DOMAINS - 1);

`ifdef UX607_RESET_SEQ_DBG_EN
    localparam logic DBG_EN = 1'b1;
`else
    localparam logic DBG_EN = 1'b0;
`endif

    rst_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                 busy_q, busy_d;
    logic [CAUSE_W-1:0]   cause_q, cause_set;

    logic                 dbg_act;
    logic                 req_act;

    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_dec;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_zero;

    // With the feature disabled the debug input is still sampled but masked to 0.
    assign dbg_act = rst_if.dbg_rst_req & DBG_EN;
    assign req_act = rst_if.sw_rst_req | rst_if.wdt_rst_req | dbg_act;

    ux607_reset_cnt #(
        .W       (CNT_W),
        .RST_VAL (STRETCH_CYCLES - 1)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ASSERT;
            idx_q     <= '0;
            rst_out_q <= '1;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_load     = 1'b0;
        cnt_load_val = STRETCH_LD;
        cnt_dec      = 1'b0;
        rst_out_d    = '0;
        busy_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_act) begin
                    state_d  = ASSERT;
                    cnt_load = 1'b1;
                end
            end
            ASSERT: begin
                if (req_act) begin
                    cnt_load = 1'b1;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_d      = RELEASE;
                    idx_d        = '0;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LD;
                end
            end
            RELEASE: begin
                if (req_act) begin
                    state_d  = ASSERT;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    idx_d        = idx_q + IDX_W'(1);
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d  = ASSERT;
                idx_d    = '0;
                cnt_load = 1'b1;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they are
        // glitch-free flops; in RELEASE every domain at or below idx is released.
        case (state_d)
            ASSERT:  rst_out_d = '1;
            RELEASE: begin
                for (int unsigned i = 0; i < N_DOMAINS; i++) begin
                    rst_out_d[i] = (i > 32'(idx_d));
                end
            end
            default: rst_out_d = '0;
        endcase
        busy_d = |rst_out_d;
    end

    always_comb begin
        cause_set            = '0;
        cause_set[CAUSE_SW]  = rst_if.sw_rst_req;
        cause_set[CAUSE_WDT] = rst_if.wdt_rst_req;
        cause_set[CAUSE_DBG] = dbg_act;
    end

    // A clear and a set in the same cycle: the set bits survive, all others drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            cause_q            <= '0;
            cause_q[CAUSE_POR] <= 1'b1;
        end else if (rst_if.io_cause_clr) begin
            cause_q <= cause_set;
        end else begin
            cause_q <= cause_q | cause_set;
        end
    end

    assign rst_if.io_rst_out   = rst_out_q;
    assign rst_if.io_rst_busy  = busy_q;
    assign rst_if.io_rst_cause = cause_q;

endmodule

// File: tb/tb_ux607_reset_sequencer.sv
// Self-checking bench for ux607_reset_sequencer: directed steps plus random
// request traffic against a "cycles since last request" reference model.
module tb_ux607_reset_sequencer;

    localparam int S = 16;
    localparam int G = 4;
    localparam int N = 3;

`ifdef UX607_RESET_SEQ_DBG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic clock;
    logic reset;

    ux607_reset_sequencer_if #(.N_DOMAINS(N)) rif ();

    ux607_reset_sequencer #(
        .STRETCH_CYCLES (S),
        .GAP_CYCLES     (G),
        .N_DOMAINS      (N)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .rst_if (rif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference: q counts edges since the last request (or reset); domain k is
    // held while q < S + k*G. Cause is a set/clear register.
    int       q;
    logic [3:0] m_cause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_out(input int qq);
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = (qq < S + k * G);
        return e;
    endfunction

    task automatic tick();
        logic req;
        logic [3:0] set;
        logic [N-1:0] e;
        @(posedge clock);
        if (reset) begin
            q       = 0;
            m_cause = 4'b0001;
        end else begin
            req = rif.sw_rst_req | rif.wdt_rst_req | (rif.dbg_rst_req & DBG);
            if (req) q = 0;
            else if (q < S + N * G + 2) q++;
            set     = {rif.dbg_rst_req & DBG, rif.wdt_rst_req, rif.sw_rst_req, 1'b0};
            m_cause = rif.io_cause_clr ? set : (m_cause | set);
        end
        #1;
        e = model_out(q);
        chk("out",   32'(rif.io_rst_out),   32'(e));
        chk("busy",  32'(rif.io_rst_busy),  32'(|e));
        chk("cause", 32'(rif.io_rst_cause), 32'(m_cause));
    endtask

    initial begin
        reset            = 1'b1;
        rif.sw_rst_req   = 1'b0;
        rif.wdt_rst_req  = 1'b0;
        rif.dbg_rst_req  = 1'b0;
        rif.io_cause_clr = 1'b0;
        q       = 0;
        m_cause = 4'b0001;

        // Power-on reset state
        repeat (3) tick();
        chk("por_out",   32'(rif.io_rst_out),   32'h7);
        chk("por_busy",  32'(rif.io_rst_busy),  32'h1);
        chk("por_cause", 32'(rif.io_rst_cause), 32'h1);

        // Release after POR: 16 / 20 / 24
        reset = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 15) chk("por_hold15", 32'(rif.io_rst_out), 32'h7);
            if (i == 16) chk("por_rel0",   32'(rif.io_rst_out), 32'h6);
            if (i == 20) chk("por_rel1",   32'(rif.io_rst_out), 32'h4);
            if (i == 24) begin
                chk("por_rel2",   32'(rif.io_rst_out),   32'h0);
                chk("por_busy0",  32'(rif.io_rst_busy),  32'h0);
                chk("por_cause1", 32'(rif.io_rst_cause), 32'h1);
            end
        end
        repeat (74) tick();

        // Clear cause, then software pulse
        rif.io_cause_clr = 1'b1; tick(); rif.io_cause_clr = 1'b0;
        chk("clr_cause", 32'(rif.io_rst_cause), 32'h0);
        rif.sw_rst_req = 1'b1; tick(); rif.sw_rst_req = 1'b0;
        chk("sw_out",   32'(rif.io_rst_out),   32'h7);
        chk("sw_cause", 32'(rif.io_rst_cause), 32'h2);
        repeat (15) tick();
        chk("sw_hold", 32'(rif.io_rst_out), 32'h7);
        tick();
        chk("sw_rel0", 32'(rif.io_rst_out), 32'h6);

        // Watchdog pulse two cycles into RELEASE restarts the sequence
        repeat (2) tick();
        rif.wdt_rst_req = 1'b1; tick(); rif.wdt_rst_req = 1'b0;
        chk("wdt_out",   32'(rif.io_rst_out),   32'h7);
        chk("wdt_cause", 32'(rif.io_rst_cause), 32'h6);
        repeat (15) tick();
        chk("wdt_hold", 32'(rif.io_rst_out), 32'h7);
        tick();
        chk("wdt_rel0", 32'(rif.io_rst_out), 32'h6);
        repeat (12) tick();

        // Build cause = 0101, then clear+sw in the same cycle
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (26) tick();
        rif.wdt_rst_req = 1'b1; tick(); rif.wdt_rst_req = 1'b0;
        repeat (26) tick();
        chk("pre_cs_cause", 32'(rif.io_rst_cause), 32'h5);
        rif.io_cause_clr = 1'b1; rif.sw_rst_req = 1'b1; tick();
        rif.io_cause_clr = 1'b0; rif.sw_rst_req = 1'b0;
        chk("clr_set_cause", 32'(rif.io_rst_cause), 32'h2);
        repeat (26) tick();

        // Debug level request held for 50 cycles
        rif.io_cause_clr = 1'b1; tick(); rif.io_cause_clr = 1'b0;
        rif.dbg_rst_req = 1'b1; repeat (50) tick(); rif.dbg_rst_req = 1'b0;
        repeat (15) tick();
        chk("dbg_hold",  32'(rif.io_rst_out),      DBG ? 32'h7 : 32'h0);
        chk("dbg_cause", 32'(rif.io_rst_cause[3]), DBG ? 32'h1 : 32'h0);
        tick();
        chk("dbg_rel0",  32'(rif.io_rst_out),      DBG ? 32'h6 : 32'h0);
        repeat (12) tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rif.sw_rst_req   = ($urandom_range(0, 59) == 0);
            rif.wdt_rst_req  = ($urandom_range(0, 69) == 0);
            rif.io_cause_clr = ($urandom_range(0, 39) == 0);
            reset            = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0) rif.dbg_rst_req = ~rif.dbg_rst_req;
            tick();
        end
        rif.sw_rst_req = 1'b0; rif.wdt_rst_req = 1'b0; rif.dbg_rst_req = 1'b0;
        rif.io_cause_clr = 1'b0; reset = 1'b0;
        repeat (40) tick();

        // Reset in the middle of RELEASE
        rif.sw_rst_req = 1'b1; tick(); rif.sw_rst_req = 1'b0;
        repeat (18) tick();
        chk("mid_rel_out", 32'(rif.io_rst_out), 32'h6);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_out",   32'(rif.io_rst_out),   32'h7);
        chk("mid_rst_busy",  32'(rif.io_rst_busy),  32'h1);
        chk("mid_rst_cause", 32'(rif.io_rst_cause), 32'h1);
        repeat (15) tick();
        chk("mid_rst_hold", 32'(rif.io_rst_out), 32'h7);
        tick();
        chk("mid_rst_rel0", 32'(rif.io_rst_out), 32'h6);
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
